pc_stack_unit: RTL
==================

# pc_stack_unit

Parametrised program-counter and hardware return-stack unit for the next-generation MCU core. It generates the fetch address and supports sequential fetch, absolute jump, conditional skip, call and return, backed by a configurable-depth return stack with overflow and underflow detection. It sits between the instruction decoder and program memory, replacing the fixed-width PC logic of the current CPU.

## Interface
- PC_W, 11, program-counter width in bits (program space 2^PC_W words).
- STACK_DEPTH, 8, number of return-stack entries (≥2, power of two).
- RESET_VEC, 0, PC value loaded on reset.
- TRAP_VEC, 4, PC loaded on stack fault (used only with PC_STACK_TRAP_EN).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- en  in  1  advance strobe; op is executed only when 1.
- op  in  3  0 NEXT, 1 GOTO, 2 CALL, 3 RET, 4 SKIPC; 5–7 behave as NEXT.
- target  in  PC_W  destination for GOTO/CALL.
- cond  in  1  skip condition for SKIPC.
- clear_err  in  1  clears sticky ovf/unf.
- pc  out  PC_W  current fetch address.
- depth  out  clog2(STACK_DEPTH)+1  valid entries on stack (0..STACK_DEPTH).
- stack_full  out  1  depth == STACK_DEPTH.
- stack_empty  out  1  depth == 0.
- ovf  out  1  sticky: CALL issued while full.
- unf  out  1  sticky: RET issued while empty.
- trap  out  1  one-cycle fault pulse (only with PC_STACK_TRAP_EN).

## Operation
- Reset: pc=RESET_VEC, depth=0, write pointer=0, ovf=unf=trap=0; stack contents not cleared.
- en=0: all state held; op/target/cond ignored.
- NEXT: pc ← pc+1, modulo 2^PC_W (wraps 2^PC_W−1 → 0).
- GOTO: pc ← target.
- SKIPC: pc ← pc+2 if cond=1, else pc+1; modulo 2^PC_W.
- CALL: push pc+1 (wrapped) at write pointer, pointer+1 mod STACK_DEPTH, depth+1 (saturates at STACK_DEPTH), pc ← target.
- RET: pointer−1 mod STACK_DEPTH, pc ← entry at new pointer, depth−1 (floors at 0).
- Stack is a circular buffer; full CALL overwrites oldest entry, sets ovf. Empty RET still pops (stale entry, pointer wraps), sets unf, depth stays 0.
- clear_err=1 clears ovf/unf on next edge; a fault on the same edge wins (flag set).
- stack_full/stack_empty/depth are combinational from registered count.

## Timing
- All state registered on rising clk; pc reflects an op one cycle after the edge where en=1 sampled it.
- One op per cycle; back-to-back CALL/RET with no bubbles.
- CALL then RET on consecutive cycles returns the CALL's pc+1.
- Reset asserted mid-operation takes effect immediately (asynchronous); release is synchronised by the caller's convention, first op executes on the first edge with reset=1.

## Configuration
- PC_STACK_TRAP_EN defined: CALL when full or RET when empty does not modify stack, pointer or depth; pc ← TRAP_VEC, ovf/unf set as normal, trap=1 for exactly one cycle following that edge.
- Not defined: circular overwrite/stale-pop behaviour above; trap port tied 0.

## Test plan
- Reset with PC_W=11: reset=0 for 15 ns → pc=0x000, depth=0, stack_empty=1; then 5 NEXT → pc=0x005.
- Wrap/skip: GOTO 0x7FE, SKIPC cond=1 → pc=0x000; SKIPC cond=0 → pc=0x001.
- Nested calls: from pc=0x010 CALL 0x100, CALL 0x200, RET, RET → pc sequence 0x100, 0x200, 0x101, 0x011; depth 1,2,1,0.
- Overflow (no macro): 9 CALLs to 0x300 from pc=0x020 → ovf=1, depth=8, stack_full=1; 8 RETs return 0x301×7 then 0x301 (oldest 0x021 lost); clear_err → ovf=0.
- Underflow: RET at depth 0 → unf=1, depth=0; with PC_STACK_TRAP_EN → pc=0x004, trap high one cycle, depth unchanged.
- en=0 for 10 cycles with op=GOTO target=0x555 → pc and depth unchanged.

Source files
------------

// File: rtl/pc_stack_unit_if.sv
// Bus between the instruction decoder and the PC / return-stack unit.
// The decoder side (master) issues op/target/cond strobes; the unit
// side (slave) returns the fetch address and stack status.
interface pc_stack_unit_if #(
  parameter int PC_W        = 11,
  parameter int STACK_DEPTH = 8
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

  logic               en;
  logic [2:0]         op;
  logic [PC_W-1:0]    target;
  logic               cond;
  logic               clear_err;
  logic [PC_W-1:0]    pc;
  logic [DEPTH_W-1:0] depth;
  logic               stack_full;
  logic               stack_empty;
  logic               ovf;
  logic               unf;
  logic               trap;

  modport master (
    output en, op, target, cond, clear_err,
    input  pc, depth, stack_full, stack_empty, ovf, unf, trap
  );

  modport slave (
    input  en, op, target, cond, clear_err,
    output pc, depth, stack_full, stack_empty, ovf, unf, trap
  );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with a circular hardware return stack.
// Ops: NEXT, GOTO, CALL, RET, SKIPC (codes 5-7 act as NEXT).
// Optional macro PC_STACK_TRAP_EN: a CALL on a full stack or a RET on an
// empty stack leaves the stack untouched, jumps to TRAP_VEC and pulses
// trap for one cycle. Without it the stack wraps (oldest entry
// overwritten / stale entry popped) and trap is tied low.
module pc_stack_unit #(
  parameter int PC_W        = 11,
  parameter int STACK_DEPTH = 8,
  parameter int RESET_VEC   = 0,
  parameter int TRAP_VEC    = 4
) (
  input  logic             clk,
  input  logic             reset,
  pc_stack_unit_if.slave   bus
);
  localparam int PTR_W   = $clog2(STACK_DEPTH);
  localparam int DEPTH_W = PTR_W + 1;

  localparam logic [2:0] OP_GOTO  = 3'd1;
  localparam logic [2:0] OP_CALL  = 3'd2;
  localparam logic [2:0] OP_RET   = 3'd3;
  localparam logic [2:0] OP_SKIPC = 3'd4;

  localparam logic [PC_W-1:0]    RESET_PC  = PC_W'(RESET_VEC);
  localparam logic [PC_W-1:0]    TRAP_PC   = PC_W'(TRAP_VEC);
  localparam logic [DEPTH_W-1:0] FULL_CNT  = DEPTH_W'(STACK_DEPTH);

`ifdef PC_STACK_TRAP_EN
  localparam bit TRAP_MODE = 1'b1;
`else
  localparam bit TRAP_MODE = 1'b0;
`endif

  logic [PC_W-1:0]    stack_mem [STACK_DEPTH];
  logic [PC_W-1:0]    pc_reg;
  logic [PTR_W-1:0]   ptr_reg;
  logic [DEPTH_W-1:0] depth_reg;
  logic               ovf_reg;
  logic               unf_reg;

  logic               is_full;
  logic               is_empty;
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    pc_inc2;
  logic [PTR_W-1:0]   ptr_dec;
  logic [PC_W-1:0]    ret_addr;
  logic               call_fault;
  logic               ret_fault;
  logic               push;

  assign is_full    = (depth_reg == FULL_CNT);
  assign is_empty   = (depth_reg == '0);
  // Power-of-two widths give the required modulo wrap for free.
  assign pc_inc     = pc_reg + PC_W'(1);
  assign pc_inc2    = pc_reg + PC_W'(2);
  assign ptr_dec    = ptr_reg - PTR_W'(1);
  // The pop must land in pc on the same edge, so the stack is read
  // asynchronously at the pre-decremented pointer.
  assign ret_addr   = stack_mem[ptr_dec];
  assign call_fault = bus.en && (bus.op == OP_CALL) && is_full;
  assign ret_fault  = bus.en && (bus.op == OP_RET) && is_empty;
  assign push       = bus.en && (bus.op == OP_CALL) && !(TRAP_MODE && is_full);

  assign bus.pc          = pc_reg;
  assign bus.depth       = depth_reg;
  assign bus.stack_full  = is_full;
  assign bus.stack_empty = is_empty;
  assign bus.ovf         = ovf_reg;
  assign bus.unf         = unf_reg;

  // Return-address storage: not reset, written only by a live CALL.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      stack_mem[ptr_reg] <= pc_inc;
    end
  end

  // PC, stack pointer, occupancy and sticky fault flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg    <= RESET_PC;
      ptr_reg   <= '0;
      depth_reg <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      if (bus.en) begin
        case (bus.op)
          OP_GOTO:  pc_reg <= bus.target;
          OP_CALL: begin
            if (TRAP_MODE && call_fault) begin
              pc_reg <= TRAP_PC;
            end else begin
              pc_reg  <= bus.target;
              ptr_reg <= ptr_reg + PTR_W'(1);
              if (!is_full) depth_reg <= depth_reg + DEPTH_W'(1);
            end
          end
          OP_RET: begin
            if (TRAP_MODE && ret_fault) begin
              pc_reg <= TRAP_PC;
            end else begin
              pc_reg  <= ret_addr;
              ptr_reg <= ptr_dec;
              if (!is_empty) depth_reg <= depth_reg - DEPTH_W'(1);
            end
          end
          OP_SKIPC: pc_reg <= bus.cond ? pc_inc2 : pc_inc;
          default:  pc_reg <= pc_inc;
        endcase
      end
      // A fault on the same edge as clear_err keeps the flag set.
      if (call_fault)         ovf_reg <= 1'b1;
      else if (bus.clear_err) ovf_reg <= 1'b0;
      if (ret_fault)          unf_reg <= 1'b1;
      else if (bus.clear_err) unf_reg <= 1'b0;
    end
  end

`ifdef PC_STACK_TRAP_EN
  logic trap_reg;

  // One-cycle pulse after any edge that took a stack fault.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) trap_reg <= 1'b0;
    else        trap_reg <= call_fault || ret_fault;
  end

  assign bus.trap = trap_reg;
`else
  assign bus.trap = 1'b0;
`endif

endmodule
